fetch_ctrl: RTL and testbench
=============================

FETCH_CTRL -- requirements
Module: fetch_ctrl

Interface
REQ-001 clk  input  1  system clock; all fetch_ctrl state updates on the rising edge.
REQ-002 reset  input  1  asynchronous, active-high reset; forces all state and outputs to reset values immediately.
REQ-003 pc_out  input  16  current program counter value from the PC block.
REQ-004 pc_inc  output  1  one-cycle pulse requesting PC = PC+1.
REQ-005 pc_load  output  1  one-cycle pulse requesting PC = pc_in.
REQ-006 pc_reset  output  1  one-cycle pulse requesting PC = 0.
REQ-007 pc_in  output  16  jump target presented to the PC with pc_load.
REQ-008 rom_req  output  1  instruction ROM read request.
REQ-009 rom_addr  output  16  ROM read address; equals pc_out whenever rom_req=1.
REQ-010 rom_ack  input  1  ROM read complete; rom_data is valid in the same cycle.
REQ-011 rom_data  input  16  ROM read data.
REQ-012 instr  output  16  instruction at the queue head.
REQ-013 instr_addr  output  16  address of the instruction at the queue head.
REQ-014 instr_valid  output  1  queue head holds a valid instruction.
REQ-015 instr_ready  input  1  consumer accepts the head; transfer occurs when instr_valid=1 and instr_ready=1.
REQ-016 jump  input  1  one-cycle redirect request from execute.
REQ-017 jump_target  input  16  redirect address; sampled only when jump=1.

Function
REQ-018 All outputs shall be registered, and pc_inc, pc_load, and pc_reset shall be mutually exclusive in every cycle.
REQ-019 The FSM shall have the states RST_PC, SETTLE, REQ, and HOLD, and no others.
REQ-020 RST_PC: pc_reset=1 for exactly one cycle, then -> SETTLE.
REQ-021 SETTLE: one cycle with no rom_req and no PC control, allowing pc_out to update; then -> REQ if the queue count is below 2, else -> HOLD.
REQ-022 REQ: rom_req=1 and rom_addr=pc_out; rom_req shall stay high until rom_ack or jump, with at most one request outstanding.
REQ-023 REQ with rom_ack=1 and jump=0 shall push {pc_out, rom_data} into the queue, pulse pc_inc next cycle, drop rom_req, and -> SETTLE.
REQ-024 HOLD: rom_req=0 until queue count is below 2, then -> REQ.
REQ-025 The queue shall be a 2-entry FIFO of {addr[15:0], data[15:0]}; instr and instr_addr shall show the head, and instr_valid shall equal (count != 0).
REQ-026 A push and a pop in the same cycle with count=1 or count=2 shall leave count unchanged and preserve order.
REQ-027 A request shall never be issued while count=2, so there is no overflow path; a pop at count=0 shall be impossible because instr_valid=0.
REQ-028 jump=1 in any state except RST_PC shall complete any same-cycle head transfer, then flush all remaining entries (count=0).
REQ-029 jump=1 shall also drop rom_req, discard any same-cycle rom_ack data, pulse pc_load with pc_in=jump_target next cycle, and -> SETTLE.
REQ-030 Abort rule: deasserting rom_req before rom_ack cancels that read; the ROM shall not ack a cancelled read.
REQ-031 jump=1 during RST_PC shall be ignored.
REQ-032 Priority shall be reset > jump > rom_ack > instr pop.
REQ-033 Address wrap: after fetching 0xFFFF, the next fetch address shall be whatever pc_out shows (0x0000); fetch_ctrl shall perform no address arithmetic.

Reset
REQ-034 On reset assertion, the block shall enter RST_PC with rom_req, pc_inc, pc_load, pc_reset, and instr_valid all 0, pc_in=0, instr=0, instr_addr=0, and queue count=0.
REQ-035 The first cycle after reset release shall have pc_reset=1.
REQ-036 Reset asserted mid-request shall drop rom_req immediately and lose all queued entries.

Verification
REQ-037 Sequential fetch, ROM ack latency 1, instr_ready=1, after reset release: pc_reset pulse, then rom_addr=0x0000, 0x0001, 0x0002, ... with instr_addr following in order.
REQ-038 Backpressure, instr_ready=0: exactly 2 entries fill and rom_req stays 0; one pop -> exactly one new request issued.
REQ-039 Jump while REQ pending at rom_addr=0x0005, jump_target=0x0100: rom_req drops, queue empties, pc_load=1 with pc_in=0x0100; next request rom_addr=0x0100, and no 0x0005 data appears at instr.
REQ-040 jump in the same cycle as rom_ack: ack data discarded, and the next instr_addr=jump_target.
REQ-041 Wrap, PC preset to 0xFFFF: instr_addr sequence 0xFFFF, 0x0000.
REQ-042 Reset asserted while count=2 and rom_req=1: asynchronously instr_valid=0 and rom_req=0; after release the sequence restarts at 0x0000.

Source files
------------

// File: rtl/fetch_ctrl.sv
// rtl/fetch_ctrl.sv - instruction fetch sequencer with a 2-entry {addr, data} queue
// Drives the PC block and instruction ROM; jump redirects flush the queue.
module fetch_ctrl (
    input  logic        i_clk,
    input  logic        i_reset,
    input  logic [15:0] i_pc_out,
    output logic        o_pc_inc,
    output logic        o_pc_load,
    output logic        o_pc_reset,
    output logic [15:0] o_pc_in,
    output logic        o_rom_req,
    output logic [15:0] o_rom_addr,
    input  logic        i_rom_ack,
    input  logic [15:0] i_rom_data,
    output logic [15:0] o_instr,
    output logic [15:0] o_instr_addr,
    output logic        o_instr_valid,
    input  logic        i_instr_ready,
    input  logic        i_jump,
    input  logic [15:0] i_jump_target
);

    typedef enum logic [1:0] {RST_PC, SETTLE, REQ, HOLD} state_t;

    state_t      r_state;
    state_t      w_state_nxt;

    logic        r_pc_inc;
    logic        r_pc_load;
    logic        r_pc_reset;
    logic [15:0] r_pc_in;
    logic        r_rom_req;
    logic [15:0] r_rom_addr;

    logic [15:0] r_q_addr [0:1];
    logic [15:0] r_q_data [0:1];
    logic [1:0]  r_count;
    logic        r_valid;

    logic        w_pc_inc;
    logic        w_pc_load;
    logic        w_pc_reset;
    logic [15:0] w_pc_in;
    logic        w_rom_req;
    logic [15:0] w_rom_addr;
    logic        w_push;
    logic        w_flush;
    logic        w_pop;
    logic [1:0]  w_cnt_after_pop;
    logic        w_room;
    logic        w_pulse_active;

    assign w_pop           = r_valid && i_instr_ready;
    assign w_cnt_after_pop = r_count - {1'b0, w_pop};
    assign w_room          = (w_cnt_after_pop < 2'd2);
    assign w_pulse_active  = r_pc_inc || r_pc_load || r_pc_reset;

    // SETTLE spans the PC-control pulse cycle plus one quiet cycle, so the
    // address captured on entry to REQ is the already-updated pc_out.
    always_comb begin
        w_state_nxt = r_state;
        w_pc_inc    = 1'b0;
        w_pc_load   = 1'b0;
        w_pc_reset  = 1'b0;
        w_pc_in     = r_pc_in;
        w_rom_req   = 1'b0;
        w_rom_addr  = r_rom_addr;
        w_push      = 1'b0;
        w_flush     = 1'b0;
        if (r_state == RST_PC) begin
            w_pc_reset  = 1'b1;
            w_state_nxt = SETTLE;
        end else if (i_jump) begin
            w_flush     = 1'b1;
            w_pc_load   = 1'b1;
            w_pc_in     = i_jump_target;
            w_state_nxt = SETTLE;
        end else begin
            case (r_state)
                SETTLE: begin
                    if (!w_pulse_active) begin
                        if (w_room) begin
                            w_rom_req   = 1'b1;
                            w_rom_addr  = i_pc_out;
                            w_state_nxt = REQ;
                        end else begin
                            w_state_nxt = HOLD;
                        end
                    end
                end
                REQ: begin
                    if (i_rom_ack) begin
                        w_push      = 1'b1;
                        w_pc_inc    = 1'b1;
                        w_state_nxt = SETTLE;
                    end else begin
                        w_rom_req = 1'b1;
                    end
                end
                HOLD: begin
                    if (w_room) begin
                        w_rom_req   = 1'b1;
                        w_rom_addr  = i_pc_out;
                        w_state_nxt = REQ;
                    end
                end
                default: w_state_nxt = RST_PC;
            endcase
        end
    end

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            r_state <= RST_PC;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            r_pc_inc   <= 1'b0;
            r_pc_load  <= 1'b0;
            r_pc_reset <= 1'b0;
            r_pc_in    <= 16'h0000;
            r_rom_req  <= 1'b0;
            r_rom_addr <= 16'h0000;
        end else begin
            r_pc_inc   <= w_pc_inc;
            r_pc_load  <= w_pc_load;
            r_pc_reset <= w_pc_reset;
            r_pc_in    <= w_pc_in;
            r_rom_req  <= w_rom_req;
            r_rom_addr <= w_rom_addr;
        end
    end

    // Entry 0 is always the head; a push can never meet count=2.
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            r_q_addr[0] <= 16'h0000;
            r_q_addr[1] <= 16'h0000;
            r_q_data[0] <= 16'h0000;
            r_q_data[1] <= 16'h0000;
            r_count     <= 2'd0;
            r_valid     <= 1'b0;
        end else if (w_flush) begin
            r_count <= 2'd0;
            r_valid <= 1'b0;
        end else begin
            case ({w_push, w_pop})
                2'b10: begin
                    r_q_addr[r_count[0]] <= i_pc_out;
                    r_q_data[r_count[0]] <= i_rom_data;
                    r_count              <= r_count + 2'd1;
                    r_valid              <= 1'b1;
                end
                2'b01: begin
                    r_q_addr[0] <= r_q_addr[1];
                    r_q_data[0] <= r_q_data[1];
                    r_count     <= r_count - 2'd1;
                    r_valid     <= (r_count == 2'd2);
                end
                2'b11: begin
                    if (r_count == 2'd1) begin
                        r_q_addr[0] <= i_pc_out;
                        r_q_data[0] <= i_rom_data;
                    end else begin
                        r_q_addr[0] <= r_q_addr[1];
                        r_q_data[0] <= r_q_data[1];
                        r_q_addr[1] <= i_pc_out;
                        r_q_data[1] <= i_rom_data;
                    end
                end
                default: ;
            endcase
        end
    end

    assign o_pc_inc      = r_pc_inc;
    assign o_pc_load     = r_pc_load;
    assign o_pc_reset    = r_pc_reset;
    assign o_pc_in       = r_pc_in;
    assign o_rom_req     = r_rom_req;
    assign o_rom_addr    = r_rom_addr;
    assign o_instr       = r_q_data[0];
    assign o_instr_addr  = r_q_addr[0];
    assign o_instr_valid = r_valid;

endmodule

// File: tb/tb_fetch_ctrl.sv
// tb/tb_fetch_ctrl.sv - directed bench for fetch_ctrl with PC and ROM models
// ROM answers one cycle after a request is seen; data = addr ^ 16'hA5A5.
module tb_fetch_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic [15:0] pc;
    logic        rom_ack;
    logic [15:0] rom_data;
    logic        instr_ready;
    logic        jump;
    logic [15:0] jump_target;

    logic        o_pc_inc;
    logic        o_pc_load;
    logic        o_pc_reset;
    logic [15:0] o_pc_in;
    logic        o_rom_req;
    logic [15:0] o_rom_addr;
    logic [15:0] o_instr;
    logic [15:0] o_instr_addr;
    logic        o_instr_valid;

    int n_cmp     = 0;
    int n_fail    = 0;
    int req_rises = 0;
    logic watch5  = 1'b0;
    logic saw5    = 1'b0;

    always #5 clk = ~clk;

    fetch_ctrl dut (
        .i_clk         (clk),
        .i_reset       (rst),
        .i_pc_out      (pc),
        .o_pc_inc      (o_pc_inc),
        .o_pc_load     (o_pc_load),
        .o_pc_reset    (o_pc_reset),
        .o_pc_in       (o_pc_in),
        .o_rom_req     (o_rom_req),
        .o_rom_addr    (o_rom_addr),
        .i_rom_ack     (rom_ack),
        .i_rom_data    (rom_data),
        .o_instr       (o_instr),
        .o_instr_addr  (o_instr_addr),
        .o_instr_valid (o_instr_valid),
        .i_instr_ready (instr_ready),
        .i_jump        (jump),
        .i_jump_target (jump_target)
    );

    typedef struct packed {
        logic        rdy;
        logic        rst;
        logic        inc;
        logic        req;
        logic [15:0] addr;
        logic        valid;
        logic [15:0] iaddr;
    } vec_t;

    vec_t vecs [13];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic tick();
        logic        p_rst, p_load, p_inc, req_prev, ack_prev;
        logic [15:0] p_in;
        p_rst    = o_pc_reset;
        p_load   = o_pc_load;
        p_inc    = o_pc_inc;
        p_in     = o_pc_in;
        req_prev = o_rom_req;
        ack_prev = rom_ack;
        @(posedge clk);
        #1;
        if (p_rst)       pc = 16'h0000;
        else if (p_load) pc = p_in;
        else if (p_inc)  pc = pc + 16'h0001;
        rom_ack  = o_rom_req && req_prev && !ack_prev;
        rom_data = o_rom_addr ^ 16'hA5A5;
        jump     = 1'b0;
        if (o_rom_req && !req_prev) req_rises++;
        if (watch5 && o_instr_valid && o_instr_addr == 16'h0005) saw5 = 1'b1;
        check("pulse_excl", 64'($countones({o_pc_inc, o_pc_load, o_pc_reset}) <= 1), 64'd1);
        if (o_rom_req) check("rom_addr_eq_pc", 64'(o_rom_addr), 64'(pc));
    endtask

    task automatic do_reset();
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
    endtask

    initial begin
        rst = 1'b1; pc = 16'h1234; rom_ack = 1'b0; rom_data = 16'h0000;
        instr_ready = 1'b1; jump = 1'b0; jump_target = 16'h0000;

        //            rdy   rst   inc   req   addr     valid iaddr
        vecs[0]  = {1'b1, 1'b1, 1'b0, 1'b0, 16'h0000, 1'b0, 16'h0000};
        vecs[1]  = {1'b1, 1'b0, 1'b0, 1'b0, 16'h0000, 1'b0, 16'h0000};
        vecs[2]  = {1'b1, 1'b0, 1'b0, 1'b1, 16'h0000, 1'b0, 16'h0000};
        vecs[3]  = {1'b1, 1'b0, 1'b0, 1'b1, 16'h0000, 1'b0, 16'h0000};
        vecs[4]  = {1'b1, 1'b0, 1'b1, 1'b0, 16'h0000, 1'b1, 16'h0000};
        vecs[5]  = {1'b1, 1'b0, 1'b0, 1'b0, 16'h0000, 1'b0, 16'h0000};
        vecs[6]  = {1'b1, 1'b0, 1'b0, 1'b1, 16'h0001, 1'b0, 16'h0000};
        vecs[7]  = {1'b1, 1'b0, 1'b0, 1'b1, 16'h0001, 1'b0, 16'h0000};
        vecs[8]  = {1'b1, 1'b0, 1'b1, 1'b0, 16'h0000, 1'b1, 16'h0001};
        vecs[9]  = {1'b1, 1'b0, 1'b0, 1'b0, 16'h0000, 1'b0, 16'h0000};
        vecs[10] = {1'b1, 1'b0, 1'b0, 1'b1, 16'h0002, 1'b0, 16'h0000};
        vecs[11] = {1'b1, 1'b0, 1'b0, 1'b1, 16'h0002, 1'b0, 16'h0000};
        vecs[12] = {1'b1, 1'b0, 1'b1, 1'b0, 16'h0000, 1'b1, 16'h0002};

        #12;
        check("reset_outputs",
              {o_pc_inc, o_pc_load, o_pc_reset, o_rom_req, o_instr_valid, o_pc_in, o_instr, o_instr_addr},
              64'd0);
        tick();
        tick();
        rst = 1'b0;

        // Sequential fetch from reset release
        for (int i = 0; i < 13; i++) begin
            instr_ready = vecs[i].rdy;
            tick();
            check($sformatf("seq_vec%0d", i),
                  {o_pc_reset, o_pc_inc, o_pc_load, o_rom_req,
                   o_rom_req ? o_rom_addr : 16'h0000, o_instr_valid,
                   o_instr_valid ? o_instr_addr : 16'h0000,
                   o_instr_valid ? o_instr : 16'h0000},
                  {vecs[i].rst, vecs[i].inc, 1'b0, vecs[i].req,
                   vecs[i].req ? vecs[i].addr : 16'h0000, vecs[i].valid,
                   vecs[i].valid ? vecs[i].iaddr : 16'h0000,
                   vecs[i].valid ? (vecs[i].iaddr ^ 16'hA5A5) : 16'h0000});
        end

        // Backpressure: two entries fill, then exactly one refill per pop
        instr_ready = 1'b0;
        do_reset();
        for (int i = 0; i < 20; i++) tick();
        req_rises = 0;
        for (int i = 0; i < 8; i++) tick();
        check("bp_full", {req_rises[7:0], o_rom_req, o_instr_valid, o_instr_addr}, {8'd0, 1'b0, 1'b1, 16'h0000});
        req_rises = 0;
        instr_ready = 1'b1;
        tick();
        instr_ready = 1'b0;
        check("bp_pop_refill", {o_instr_addr, o_rom_req, o_rom_addr}, {16'h0001, 1'b1, 16'h0002});
        for (int i = 0; i < 12; i++) tick();
        check("bp_one_request", {req_rises[7:0], o_rom_req, o_instr_addr}, {8'd1, 1'b0, 16'h0001});
        instr_ready = 1'b1;
        tick();
        instr_ready = 1'b0;
        check("bp_order", {o_instr_valid, o_instr_addr}, {1'b1, 16'h0002});

        // Jump while request pending, with one entry queued
        do_reset();
        for (int i = 0; i < 20 && !o_rom_req; i++) tick();
        check("jmp_req0_seen", {o_rom_req, o_rom_addr}, {1'b1, 16'h0000});
        jump = 1'b1; jump_target = 16'h0004;
        tick();
        check("jmp4_load", {o_pc_load, o_pc_in, o_rom_req, o_instr_valid}, {1'b1, 16'h0004, 1'b0, 1'b0});
        for (int i = 0; i < 40 && !(o_rom_req && o_rom_addr == 16'h0005 && !rom_ack); i++) tick();
        check("jmp_req5_pending", {o_rom_req, o_rom_addr, o_instr_valid, o_instr_addr},
              {1'b1, 16'h0005, 1'b1, 16'h0004});
        watch5 = 1'b1;
        jump = 1'b1; jump_target = 16'h0100;
        tick();
        check("jmp100_flush", {o_rom_req, o_instr_valid, o_pc_load, o_pc_in}, {1'b0, 1'b0, 1'b1, 16'h0100});
        instr_ready = 1'b1;
        for (int i = 0; i < 20 && !o_rom_req; i++) tick();
        check("jmp100_req_addr", {o_rom_req, o_rom_addr}, {1'b1, 16'h0100});
        for (int i = 0; i < 20 && !o_instr_valid; i++) tick();
        check("jmp100_instr_addr", {o_instr_valid, o_instr_addr}, {1'b1, 16'h0100});

        // Jump coinciding with rom_ack discards the returned data
        for (int i = 0; i < 20 && !(o_rom_req && rom_ack); i++) tick();
        check("jmpack_seen", {o_rom_req, rom_ack}, {1'b1, 1'b1});
        jump = 1'b1; jump_target = 16'h0200;
        tick();
        for (int i = 0; i < 30 && !o_instr_valid; i++) tick();
        check("jmpack_instr_addr", {o_instr_valid, o_instr_addr}, {1'b1, 16'h0200});
        watch5 = 1'b0;
        check("jmp_no_addr5", 64'(saw5), 64'd0);

        // Address wrap from 0xFFFF
        jump = 1'b1; jump_target = 16'hFFFF;
        tick();
        for (int i = 0; i < 30 && !o_instr_valid; i++) tick();
        check("wrap_ffff", {o_instr_valid, o_instr_addr, o_instr}, {1'b1, 16'hFFFF, 16'hFFFF ^ 16'hA5A5});
        tick();
        for (int i = 0; i < 30 && !o_instr_valid; i++) tick();
        check("wrap_0000", {o_instr_valid, o_instr_addr}, {1'b1, 16'h0000});

        // Reset in the middle of a request with an entry queued
        instr_ready = 1'b0;
        jump = 1'b1; jump_target = 16'h0010;
        tick();
        for (int i = 0; i < 40 && !(o_rom_req && o_instr_valid); i++) tick();
        check("midrst_busy", {o_rom_req, o_instr_valid, o_instr_addr}, {1'b1, 1'b1, 16'h0010});
        rst = 1'b1;
        #1;
        check("midrst_async", {o_rom_req, o_instr_valid, o_pc_inc, o_pc_load, o_pc_reset}, 64'd0);
        tick();
        tick();
        rst = 1'b0;
        instr_ready = 1'b1;
        tick();
        check("midrst_pc_reset", 64'(o_pc_reset), 64'd1);
        for (int i = 0; i < 20 && !o_rom_req; i++) tick();
        check("midrst_req_addr", {o_rom_req, o_rom_addr}, {1'b1, 16'h0000});
        for (int i = 0; i < 20 && !o_instr_valid; i++) tick();
        check("midrst_instr_addr", {o_instr_valid, o_instr_addr}, {1'b1, 16'h0000});

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
